srt_stim_checker: RTL and testbench

- Master on the sorter's SDU_DM-style data-memory port: loads a test array, triggers the sort, waits for completion, then reads back and verifies the result.
- Fills word 0 with the last index N and words 1..N with LFSR data, then drives the sorter's run input and waits on its done/cycles outputs.
- Checks ascending order and checksum, and reports pass/fail, error count and captured sort cycle count.
- Used for on-board self-test and simulation regression of the sorter.

---
 rtl/srt_stim_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_srt_stim_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : srt_stim_checker
// Purpose  : Data-memory master that loads an LFSR test array into the
//            sorter's memory, triggers the sort, waits for completion, reads
//            the array back and checks ascending order plus checksum.
// Revision : 1.0 - initial release
// ============================================================================
module srt_stim_checker #(
  parameter logic [31:0] SEED     = 32'hACE1_2345,
  parameter int          RUN_HOLD = 4,
  parameter int          TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [4:0]  len_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_dout_i,
  output logic        srt_run_o,
  input  logic        srt_done_i,
  input  logic [15:0] srt_cycles_i,
  output logic        busy_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic [5:0]  err_cnt_o,
  output logic [15:0] sort_cycles_o,
  output logic        timeout_o
);

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [31:0] C_SEED      = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] C_HOLD_LAST = 32'(RUN_HOLD - 1);
  localparam logic [31:0] C_WD_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_SIZE   = 3'd1,
    S_WR_DATA   = 3'd2,
    S_RUN       = 3'd3,
    S_WAIT_FALL = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_RD_CHECK  = 3'd6,
    S_REPORT    = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  n_q, n_d;
  logic [4:0]  k_q, k_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] sum_w_q, sum_w_d;
  logic [31:0] sum_r_q, sum_r_d;
  logic [31:0] prev_q, prev_d;
  logic [31:0] cnt_q, cnt_d;      // RUN hold counter, then watchdog counter
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [5:0]  err_q, err_d;
  logic [15:0] sc_q, sc_d;
  logic        to_q, to_d;
  logic        w_ok;

  // Next-state, datapath updates and memory/sorter handshake outputs.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    lfsr_d     = lfsr_q;
    sum_w_d    = sum_w_q;
    sum_r_d    = sum_r_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
    sc_d       = sc_q;
    to_d       = to_q;
    w_ok       = 1'b0;
    mem_addr_o = 32'h0;
    mem_din_o  = 32'h0;
    mem_we_o   = 1'b0;
    srt_run_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pass_d = 1'b0;
          to_d   = 1'b0;
          err_d  = 6'd0;
          if (len_i != 5'd0) begin
            fail_d  = 1'b0;
            n_d     = len_i;
            sum_w_d = 32'h0;
            sum_r_d = 32'h0;
            state_d = S_WR_SIZE;
          end else begin
            // An empty array cannot be tested; flag it without touching memory.
            fail_d = 1'b1;
          end
        end
      end

      S_WR_SIZE: begin
        mem_addr_o = 32'h0;
        mem_din_o  = {27'b0, n_q};
        mem_we_o   = 1'b1;
        k_d        = 5'd1;
        state_d    = S_WR_DATA;
      end

      S_WR_DATA: begin
        mem_addr_o = {27'b0, k_q};
        mem_din_o  = lfsr_q;
        mem_we_o   = 1'b1;
        sum_w_d    = sum_w_q + lfsr_q;
        lfsr_d     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        if (k_q == n_q) begin
          cnt_d   = 32'h0;
          state_d = S_RUN;
        end else begin
          k_d = k_q + 5'd1;
        end
      end

      S_RUN: begin
        srt_run_o = 1'b1;
        if (cnt_q == C_HOLD_LAST) begin
          cnt_d   = 32'h0;
          state_d = S_WAIT_FALL;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_WAIT_FALL, S_WAIT_DONE: begin
        // One watchdog spans both wait states; expiry wins over a done edge.
        if (cnt_q == C_WD_LAST) begin
          to_d    = 1'b1;
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (state_q == S_WAIT_FALL) begin
            if (!srt_done_i) state_d = S_WAIT_DONE;
          end else if (srt_done_i) begin
            sc_d    = srt_cycles_i;
            k_d     = 5'd1;
            prev_d  = 32'h0;
            state_d = S_RD_CHECK;
          end
        end
      end

      S_RD_CHECK: begin
        mem_addr_o = {27'b0, k_q};
        if ((k_q > 5'd1) && (mem_dout_i < prev_q) && (err_q != 6'd63)) begin
          err_d = err_q + 6'd1;
        end
        prev_d  = mem_dout_i;
        sum_r_d = sum_r_q + mem_dout_i;
        if (k_q == n_q) begin
          state_d = S_REPORT;
        end else begin
          k_d = k_q + 5'd1;
        end
      end

      S_REPORT: begin
        w_ok    = (err_q == 6'd0) && (sum_r_q == sum_w_q);
        pass_d  = w_ok;
        fail_d  = !w_ok;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      n_q     <= 5'd0;
      k_q     <= 5'd0;
      lfsr_q  <= C_SEED;
      sum_w_q <= 32'h0;
      sum_r_q <= 32'h0;
      prev_q  <= 32'h0;
      cnt_q   <= 32'h0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 6'd0;
      sc_q    <= 16'h0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      sum_w_q <= sum_w_d;
      sum_r_q <= sum_r_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      sc_q    <= sc_d;
      to_q    <= to_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign err_cnt_o     = err_q;
  assign sort_cycles_o = sc_q;
  assign timeout_o     = to_q;

endmodule
`default_nettype wire

// File: tb/tb_srt_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_srt_stim_checker
// Purpose  : Self-checking bench for srt_stim_checker with a behavioural
//            memory + sorter model and a timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srt_stim_checker;

  localparam logic [31:0] SEED     = 32'h1;
  localparam int          RUN_HOLD = 4;
  localparam int          TIMEOUT  = 20;
  localparam int M_NORMAL = 0, M_NOSORT = 1, M_CORRUPT = 2, M_STUCK = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  len_i = 5'd0;
  logic [31:0] mem_addr_o, mem_din_o, mem_dout_i;
  logic        mem_we_o, srt_run_o, srt_done_i;
  logic [15:0] srt_cycles_i, sort_cycles_o;
  logic        busy_o, pass_o, fail_o, timeout_o;
  logic [5:0]  err_cnt_o;

  logic [31:0] mem [0:31];
  logic [15:0] m_sc;
  int          mode = M_NORMAL;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  srt_stim_checker #(.SEED(SEED), .RUN_HOLD(RUN_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i),
    .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_we_o(mem_we_o),
    .mem_dout_i(mem_dout_i), .srt_run_o(srt_run_o), .srt_done_i(srt_done_i),
    .srt_cycles_i(srt_cycles_i), .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o),
    .err_cnt_o(err_cnt_o), .sort_cycles_o(sort_cycles_o), .timeout_o(timeout_o)
  );

  assign mem_dout_i = mem[mem_addr_o[4:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Behavioural memory and sorter: needs two consecutive run cycles to start,
  // then keeps done low for a random time before sorting words 1..mem[0].
  initial begin : sorter
    logic        smp_we, smp_run;
    logic [31:0] smp_addr, smp_din, t;
    logic [31:0] a [0:31];
    int          s_run_cnt, s_cnt, s_left, n;
    bit          s_busy;
    s_busy = 0; s_run_cnt = 0; s_cnt = 0; s_left = 0;
    srt_done_i = 1'b1; srt_cycles_i = 16'h0; m_sc = 16'h0;
    forever begin
      @(negedge clk);
      smp_we = mem_we_o; smp_addr = mem_addr_o; smp_din = mem_din_o; smp_run = srt_run_o;
      @(posedge clk);
      if (!rstn) begin
        s_busy = 0; s_run_cnt = 0;
        srt_done_i <= 1'b1; srt_cycles_i <= 16'h0; m_sc <= 16'h0;
      end else begin
        if (smp_we) mem[smp_addr[4:0]] <= smp_din;
        if (!s_busy) begin
          if (smp_run && s_run_cnt == 1 && mode != M_STUCK) begin
            s_busy = 1; s_cnt = 1; s_left = int'($urandom_range(14, 6));
            srt_done_i <= 1'b0;
          end
          s_run_cnt = smp_run ? s_run_cnt + 1 : 0;
        end else if (s_cnt == s_left) begin
          n = int'(mem[0][4:0]);
          for (int i = 0; i < 32; i++) a[i] = mem[i];
          if (mode == M_CORRUPT) a[2] = 32'h0;
          if (mode == M_NOSORT) begin
            a[1] = 32'd9; a[2] = 32'd3; a[3] = 32'd7; a[4] = 32'd1;
          end else begin
            for (int i = 1; i <= n; i++)
              for (int j = 1; j < n; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
          end
          for (int i = 1; i <= n; i++) mem[i] <= a[i];
          srt_done_i   <= 1'b1;
          srt_cycles_i <= 16'(s_cnt + 2);
          m_sc         <= 16'(s_cnt + 2);
          s_busy = 0; s_run_cnt = 0;
        end else begin
          s_cnt++;
        end
      end
    end
  end

  // Reference model and single compare process: expected write/run timeline
  // relative to start, expected LFSR data, and end-of-run result from memory.
  initial begin : compare
    bit          active, zero_pend, exp_we, exp_run, exp_busy, exp_pass;
    int          rel, n_exp, md, exp_err;
    logic [31:0] exp_w [0:31];
    logic [31:0] sum_exp, sum_m, lfsr_m;
    active = 0; zero_pend = 0; rel = 0; n_exp = 0; md = 0; lfsr_m = SEED; sum_exp = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        active = 0; zero_pend = 0; lfsr_m = SEED;
        continue;
      end
      if (zero_pend) begin
        check("len0_fail", 32'(fail_o), 32'd1);
        check("len0_pass", 32'(pass_o), 32'd0);
        check("len0_busy", 32'(busy_o), 32'd0);
        zero_pend = 0;
      end
      check("addr_upper", 32'(mem_addr_o[31:5]), 32'd0);
      if (active) begin
        rel++;
        exp_we  = (rel >= 0) && (rel <= n_exp);
        exp_run = (rel > n_exp) && (rel <= n_exp + RUN_HOLD);
        check("mem_we", 32'(mem_we_o), 32'(exp_we));
        check("srt_run", 32'(srt_run_o), 32'(exp_run));
        if (exp_we) begin
          check("wr_addr", mem_addr_o, 32'(rel));
          check("wr_data", mem_din_o, exp_w[rel]);
        end
        if (md == M_STUCK) begin
          exp_busy = rel < n_exp + RUN_HOLD + 1 + TIMEOUT;
          check("wd_busy", 32'(busy_o), 32'(exp_busy));
          check("wd_timeout", 32'(timeout_o), 32'(!exp_busy));
          if (!exp_busy) begin
            check("wd_fail", 32'(fail_o), 32'd1);
            check("wd_pass", 32'(pass_o), 32'd0);
            active = 0;
          end
        end else if (rel <= n_exp + RUN_HOLD) begin
          check("busy_early", 32'(busy_o), 32'd1);
        end else if (!busy_o) begin
          exp_err = 0; sum_m = 0;
          for (int i = 1; i <= n_exp; i++) begin
            sum_m += mem[i];
            if (i > 1 && mem[i] < mem[i-1] && exp_err < 63) exp_err++;
          end
          exp_pass = (exp_err == 0) && (sum_m == sum_exp);
          check("err_cnt", 32'(err_cnt_o), 32'(exp_err));
          check("pass", 32'(pass_o), 32'(exp_pass));
          check("fail", 32'(fail_o), 32'(!exp_pass));
          check("timeout", 32'(timeout_o), 32'd0);
          check("sort_cycles", 32'(sort_cycles_o), 32'(m_sc));
          active = 0;
        end else if (rel > 400) begin
          check("run_budget", 32'(busy_o), 32'd0);
          active = 0;
        end
      end else begin
        check("idle_we", 32'(mem_we_o), 32'd0);
        check("idle_run", 32'(srt_run_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
      end
      if (!busy_o && start_i) begin
        if (len_i == 5'd0) begin
          zero_pend = 1;
        end else begin
          active = 1; rel = -1; n_exp = int'(len_i); md = mode;
          exp_w[0] = {27'b0, len_i}; sum_exp = 0;
          for (int i = 1; i <= n_exp; i++) begin
            exp_w[i] = lfsr_m; sum_exp += lfsr_m; lfsr_m = lfsr_next(lfsr_m);
          end
        end
      end
    end
  end

  task automatic run(input int n, input int m);
    int lim;
    @(posedge clk); #1;
    mode = m; start_i = 1'b1; len_i = 5'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
    lim = 0;
    while (busy_o && lim < 400) begin
      @(posedge clk); #1;
      lim++;
    end
    check("run_terminates", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, mem_addr_o, 32'd0);
    check({tag, "_din"}, mem_din_o, 32'd0);
    check({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_run"}, 32'(srt_run_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_pass"}, 32'(pass_o), 32'd0);
    check({tag, "_fail"}, 32'(fail_o), 32'd0);
    check({tag, "_err"}, 32'(err_cnt_o), 32'd0);
    check({tag, "_sc"}, 32'(sort_cycles_o), 32'd0);
    check({tag, "_to"}, 32'(timeout_o), 32'd0);
  endtask

  initial begin : stim
    int  lim;
    bit  seen;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Seed 1 gives LFSR words 1, 3, 6, 13; already ascending after sorting.
    run(4, M_NORMAL);
    check("r4_pass", 32'(pass_o), 32'd1);
    check("r4_err", 32'(err_cnt_o), 32'd0);
    check("r4_w0", mem[0], 32'd4);
    check("r4_w1", mem[1], 32'd1);
    check("r4_w2", mem[2], 32'd3);
    check("r4_w3", mem[3], 32'd6);
    check("r4_w4", mem[4], 32'd13);

    run(31, M_NORMAL);
    check("r31_pass", 32'(pass_o), 32'd1);
    check("r31_to", 32'(timeout_o), 32'd0);
    check("r31_sc_nonzero", 32'(sort_cycles_o != 16'h0), 32'd1);

    repeat (6) run(int'($urandom_range(31, 1)), M_NORMAL);

    // Sorter leaves 9,3,7,1: descents at 3<9 and 1<7.
    run(4, M_NOSORT);
    check("nosort_err", 32'(err_cnt_o), 32'd2);
    check("nosort_fail", 32'(fail_o), 32'd1);

    run(4, M_CORRUPT);
    check("corrupt_err", 32'(err_cnt_o), 32'd0);
    check("corrupt_fail", 32'(fail_o), 32'd1);
    check("corrupt_pass", 32'(pass_o), 32'd0);

    run(3, M_STUCK);
    check("stuck_to", 32'(timeout_o), 32'd1);
    check("stuck_fail", 32'(fail_o), 32'd1);

    run(0, M_NORMAL);
    check("len0_fail_after", 32'(fail_o), 32'd1);
    check("len0_to_cleared", 32'(timeout_o), 32'd0);

    // Reset in the middle of the data writes, at word 3.
    @(posedge clk); #1;
    mode = M_NORMAL; start_i = 1'b1; len_i = 5'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    lim = 0; seen = 0;
    while (!seen && lim < 50) begin
      @(negedge clk); #1;
      seen = mem_we_o && (mem_addr_o == 32'd3);
      lim++;
    end
    check("reach_k3", 32'(seen), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(2, M_NORMAL);
    check("after_reset_pass", 32'(pass_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : global_guard
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
